// File: rtl/ser_pkg.sv
// Shared constants and types for the serial-in, parallel-out word assembler.
package ser_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } ostate_t;

endpackage

// File: rtl/bit_demux_1_to_n.sv
// One-hot write-enable decoder: inverse of the bit-select mux on the serialising side.
module bit_demux_1_to_n
  import ser_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned CNT_W = cnt_w(WIDTH)
) (
  input  logic [CNT_W-1:0] bit_idx,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] wr_en
);

  always_comb begin
    wr_en = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sin_valid && (bit_idx == CNT_W'(i))) wr_en[i] = 1'b1;
    end
  end

endmodule

// File: rtl/serial_deserializer_8.sv
// Serial-in, parallel-out word assembler with a held output register
// offered through a valid/ready handshake and a sticky overrun flag.
module serial_deserializer_8
  import ser_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             msb_first,
  input  logic             clear,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_idx
);

  logic [CNT_W-1:0] cnt;
  logic             frame_msb;
  logic [WIDTH-1:0] asm_reg;
  logic [WIDTH-1:0] asm_next;
  logic [WIDTH-1:0] wr_en;
  logic             dir_msb;
  logic             complete;
  logic             handshake;
  ostate_t          state;

  // The first bit of a frame follows the live pin; later bits use the latched direction.
  assign dir_msb   = (cnt == '0) ? msb_first : frame_msb;
  assign bit_idx   = dir_msb ? (CNT_W'(WIDTH - 1) - cnt) : cnt;
  assign complete  = sin_valid && (cnt == CNT_W'(WIDTH - 1));
  assign par_valid = (state == S_FULL);
  assign handshake = par_valid && par_ready;

  bit_demux_1_to_n #(.WIDTH(WIDTH)) u_demux (
    .bit_idx  (bit_idx),
    .sin_valid(sin_valid),
    .wr_en    (wr_en)
  );

  always_comb begin
    asm_next = asm_reg;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (wr_en[i]) asm_next[i] = sin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      frame_msb <= 1'b0;
      asm_reg   <= '0;
      par_out   <= '0;
      overrun   <= 1'b0;
      state     <= S_EMPTY;
    end else if (clear) begin
      cnt       <= '0;
      frame_msb <= 1'b0;
      asm_reg   <= '0;
      par_out   <= '0;
      overrun   <= 1'b0;
      state     <= S_EMPTY;
    end else begin
      if (sin_valid) begin
        asm_reg <= asm_next;
        cnt     <= cnt + 1'b1;
        if (cnt == '0) frame_msb <= msb_first;
      end
      case (state)
        S_EMPTY: begin
          if (complete) begin
            par_out <= asm_next;
            state   <= S_FULL;
          end
        end
        S_FULL: begin
          if (complete && handshake) begin
            par_out <= asm_next;
          end else if (complete) begin
            overrun <= 1'b1;
          end else if (handshake) begin
            state <= S_EMPTY;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_deserializer_8.sv
// Self-checking bench for serial_deserializer_8: directed table, corner sequences, random traffic.
module tb_serial_deserializer_8;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sin;
  logic         sin_valid;
  logic         msb_first;
  logic         clear;
  logic         par_ready;
  logic [W-1:0] par_out;
  logic         par_valid;
  logic         overrun;
  logic [2:0]   bit_idx;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: bits of the current frame, frame direction, output register.
  int           m_q[$];
  bit           m_fmsb;
  logic [W-1:0] m_out;
  bit           m_valid;
  bit           m_ovr;

  typedef struct {
    bit         sv, s, msb, clr, rdy;
    logic [2:0] e_idx;
    logic [7:0] e_out;
    bit         e_valid, e_ovr;
  } vec_t;

  vec_t tbl[9];

  serial_deserializer_8 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sin      (sin),
    .sin_valid(sin_valid),
    .msb_first(msb_first),
    .clear    (clear),
    .par_out  (par_out),
    .par_valid(par_valid),
    .par_ready(par_ready),
    .overrun  (overrun),
    .bit_idx  (bit_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_fmsb  = 1'b0;
    m_out   = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  function automatic int unsigned exp_idx(input bit msb);
    int unsigned n;
    bit d;
    n = m_q.size();
    d = (n == 0) ? msb : m_fmsb;
    return d ? (W - 1 - n) : n;
  endfunction

  task automatic model_edge(input bit sv, input bit s, input bit msb, input bit clr, input bit rdy);
    bit           hs;
    bit           done;
    logic [W-1:0] word;
    hs   = m_valid && rdy;
    done = 1'b0;
    word = '0;
    if (clr) begin
      m_reset();
      return;
    end
    if (sv) begin
      if (m_q.size() == 0) m_fmsb = msb;
      m_q.push_back(int'(s));
      if (m_q.size() == W) begin
        for (int k = 0; k < W; k++)
          if (m_q[k] != 0) word[m_fmsb ? (W - 1 - k) : k] = 1'b1;
        m_q.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_valid || hs) begin
        m_out   = word;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (hs) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input bit sv, input bit s, input bit msb, input bit clr, input bit rdy);
    sin_valid = sv;
    sin       = s;
    msb_first = msb;
    clear     = clr;
    par_ready = rdy;
    #1;
    check("bit_idx", 32'(bit_idx), 32'(exp_idx(msb)));
    @(posedge clk);
    model_edge(sv, s, msb, clr, rdy);
    #1;
    check("par_out", 32'(par_out), 32'(m_out));
    check("par_valid", 32'(par_valid), 32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic send_word(input logic [7:0] word, input bit msb, input bit rdy, input bit rdy_last);
    logic [7:0] w;
    w = word;
    for (int k = 0; k < W; k++)
      step(1'b1, msb ? w[W - 1 - k] : w[k], msb, 1'b0, (k == W - 1) ? rdy_last : rdy);
  endtask

  initial begin
    logic [7:0] pat;
    pat       = 8'h4D;
    rst_n     = 1'b0;
    sin       = 1'b0;
    sin_valid = 1'b0;
    msb_first = 1'b0;
    clear     = 1'b0;
    par_ready = 1'b0;
    m_reset();
    #12;
    check("rst_par_out", 32'(par_out), 32'h0);
    check("rst_par_valid", 32'(par_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_bit_idx", 32'(bit_idx), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LSB-first continuous frame 8'h4D, consumer always ready.
    for (int k = 0; k < 8; k++)
      tbl[k] = '{1'b1, pat[k], 1'b0, 1'b0, 1'b1, 3'(k),
                 (k == 7) ? 8'h4D : 8'h00, (k == 7), 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h4D, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      sin_valid = tbl[i].sv;
      sin       = tbl[i].s;
      msb_first = tbl[i].msb;
      clear     = tbl[i].clr;
      par_ready = tbl[i].rdy;
      #1;
      check("tbl_bit_idx", 32'(bit_idx), 32'(tbl[i].e_idx));
      @(posedge clk);
      model_edge(tbl[i].sv, tbl[i].s, tbl[i].msb, tbl[i].clr, tbl[i].rdy);
      #1;
      check("tbl_par_out", 32'(par_out), 32'(tbl[i].e_out));
      check("tbl_par_valid", 32'(par_valid), 32'(tbl[i].e_valid));
      check("tbl_overrun", 32'(overrun), 32'(tbl[i].e_ovr));
    end

    // MSB-first with a gap after every accepted bit.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, pat[k], 1'b1, 1'b0, 1'b1);
      if (k < 7) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    end
    check("msb_gap_word", 32'(par_out), 32'hB2);
    check("msb_gap_valid", 32'(par_valid), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Direction pin flips mid-frame: this frame stays LSB-first, the next is MSB-first.
    for (int k = 0; k < 8; k++) step(1'b1, pat[k], (k >= 3), 1'b0, 1'b1);
    check("dir_latch_word", 32'(par_out), 32'h4D);
    send_word(8'h96, 1'b1, 1'b1, 1'b1);
    check("msb_next_word", 32'(par_out), 32'h96);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure over two frames, then release.
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    check("bp_word_held", 32'(par_out), 32'hA5);
    check("bp_overrun", 32'(overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_valid_drop", 32'(par_valid), 32'h0);
    check("bp_overrun_sticky", 32'(overrun), 32'h1);

    // Completion and handshake in the same cycle.
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b1);
    check("same_cycle_word", 32'(par_out), 32'h22);
    check("same_cycle_valid", 32'(par_valid), 32'h1);

    // Clear at cnt=5 with a pending word and overrun set.
    for (int k = 0; k < 5; k++) step(1'b1, k[0], 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("clr_par_out", 32'(par_out), 32'h0);
    check("clr_par_valid", 32'(par_valid), 32'h0);
    check("clr_overrun", 32'(overrun), 32'h0);
    send_word(8'hFF, 1'b0, 1'b1, 1'b1);
    check("post_clr_word", 32'(par_out), 32'hFF);

    // Asynchronous reset mid-period at cnt=3.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_par_out", 32'(par_out), 32'h0);
    check("async_par_valid", 32'(par_valid), 32'h0);
    check("async_overrun", 32'(overrun), 32'h0);
    check("async_bit_idx", 32'(bit_idx), 32'h0);
    #2;
    rst_n = 1'b1;
    m_reset();
    send_word(8'h01, 1'b0, 1'b1, 1'b1);
    check("post_rst_word", 32'(par_out), 32'h01);
    check("post_rst_valid", 32'(par_valid), 32'h1);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++)
      step(($urandom % 4) != 0, $urandom % 2 == 1, $urandom % 2 == 1,
           ($urandom % 80) == 0, ($urandom % 3) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_deserializer_8.md
# serial_deserializer_8

Serial-in, parallel-out word assembler for the universal shift register datapath; the receiving counterpart of the 8:1 bit-select path that serialises a byte. Each valid serial bit is steered into the bit position given by an internal bit index. After WIDTH bits, the assembled word moves to a held output register and is offered through a valid/ready handshake. A second assembly register keeps accepting bits while the output word waits.

## Interface
- WIDTH, 8, word width in bits; legal values are powers of two from 2 to 32.
- CNT_W, $clog2(WIDTH), bit-index width; derived, never overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sin  in  1  serial data bit.
- sin_valid  in  1  qualifies sin; one bit is accepted per cycle while high.
- msb_first  in  1  0 = first bit lands in bit 0; 1 = first bit lands in bit WIDTH-1.
- clear  in  1  synchronous flush of the whole block.
- par_out  out  WIDTH  assembled word, held stable while par_valid=1.
- par_valid  out  1  par_out holds an unconsumed word.
- par_ready  in  1  consumer accepts par_out when par_valid & par_ready.
- overrun  out  1  sticky; set when a completed word is dropped.
- bit_idx  out  CNT_W  bit position the next accepted bit will be written to.

## Operation
- Bit counter cnt runs 0..WIDTH-1 and counts bits accepted in the current frame.
- msb_first is latched into frame_msb when the frame's first bit is accepted (cnt=0). A change mid-frame has no effect until the next frame.
- bit_idx = cnt when the direction is LSB-first, and WIDTH-1-cnt when MSB-first.
  - At cnt=0 the direction used is the live msb_first input; otherwise it is frame_msb.
- Accepted bit: asm_reg[bit_idx] <= sin and cnt <= cnt+1. Unaddressed bits of asm_reg keep their value.
- Frame completion happens when a bit is accepted at cnt=WIDTH-1. The completed word (asm_reg with the final bit merged) is handed to the output stage, and cnt wraps to 0.
- Output stage FSM:
  - EMPTY (par_valid=0): on completion, par_out <= word and the FSM goes to FULL.
  - FULL (par_valid=1): on handshake with no completion, the FSM goes to EMPTY.
  - FULL, handshake and completion in the same cycle: par_out <= new word and the FSM stays in FULL with no bubble.
  - FULL, completion with no handshake: the new word is dropped, par_out is unchanged, overrun <= 1, and the counter still wraps.
- overrun stays high until clear or reset.
- clear has priority over everything. cnt, asm_reg, par_out, par_valid and overrun go to 0, the FSM goes to EMPTY, and any bit presented in the same cycle is discarded.
- When sin_valid=0, cnt and asm_reg hold. Gaps of any length inside a frame are legal.

## Timing
- Reset values: par_out=0, par_valid=0, overrun=0, bit_idx=0 (cnt=0, frame_msb=0), FSM in EMPTY.
- Reset asserted mid-frame: the partial word is lost and the next accepted bit is bit 0 of a new frame.
- Latency: the final bit is sampled at edge N; par_valid and par_out are visible after edge N and before edge N+1.
- Throughput: one word per WIDTH accepted bits. A consumer holding par_ready=1 never causes an overrun.
- par_out and par_valid come straight from registers; there is no combinational path from sin to the outputs.
- bit_idx is combinational from cnt, frame_msb and msb_first.
- par_ready is ignored while par_valid=0.

## Structure
- Package ser_pkg holds:
  - the default WIDTH constant;
  - the CNT_W derivation;
  - the output-stage state enum {S_EMPTY, S_FULL}.
- Sub-module bit_demux_1_to_n is the inverse of the bit-select mux. It is combinational; inputs are bit_idx and sin_valid, and its output is a one-hot WIDTH-bit write enable for asm_reg.
- Top level holds the counter, frame_msb, asm_reg, the output FSM and the overrun flag.

## Test plan
- LSB-first, continuous: bits 1,0,1,1,0,0,1,0 with sin_valid=1 and par_ready=1 → par_out=8'h4D, par_valid pulses for 1 cycle after the 8th edge, bit_idx sequence 0..7.
- MSB-first with gaps: the same bit sequence with sin_valid toggling every cycle → par_out=8'hB2; par_valid only after the 8th accepted bit.
- msb_first is changed from 0 to 1 after bit 3 → the word is still assembled LSB-first as 8'h4D, and the next frame is MSB-first.
- Backpressure: par_ready=0 over two full frames 8'hA5 then 8'h3C → par_out stays 8'hA5 and overrun=1. A later handshake clears par_valid and leaves overrun at 1.
  - Same-cycle completion and handshake → par_out updates to the new word and par_valid stays 1.
- clear asserted at cnt=5 with par_valid=1 and overrun=1 → all outputs are 0 next cycle, and the next frame 8'hFF assembles correctly.
- rst_n asserted asynchronously mid-clock-period at cnt=3 → outputs go to 0 immediately, without waiting for a clock edge. After release, a full frame 8'h01 is received correctly.
